pulse_schedule_ctrl: RTL and testbench
======================================

PULSE_SCHEDULE_CTRL -- requirements
Module: pulse_schedule_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of pulse channels scheduled.
REQ-002 The block SHALL have parameter PPS_TIMEOUT_CLKS, default 32'd12_000_000, meaning the clocks without a PPS edge before PPS is declared lost.
REQ-003 The block SHALL have port i_clk, input, 1, the single system clock; all logic is synchronous to its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port i_pps_raw, input, 1, asynchronous PPS pulse.
REQ-006 The block SHALL have ports i_cfg_valid (input, 1), o_cfg_ready (output, 1), i_cfg_ch (input, 2), i_cfg_addr (input, 2) and i_cfg_data (input, 32), forming the host config write channel.
REQ-007 The block SHALL have port o_ch_enable, output, NUM_CH, the per-channel pulse-generator enable.
REQ-008 The block SHALL have ports o_width_high and o_width_period, outputs, 32*NUM_CH each, the packed active per-channel widths in microseconds.
REQ-009 The block SHALL have ports o_pps_lost (output, 1), a sticky fault flag, and o_ch_state (output, 3*NUM_CH), the packed per-channel state.

Function
REQ-010 The block SHALL synchronise i_pps_raw through 2 flops and produce a one-cycle pps_tick on a detected 0->1 transition.
REQ-011 The config write SHALL complete on a cycle with i_cfg_valid=1 and o_cfg_ready=1; o_cfg_ready SHALL be 0 only on a pps_tick cycle, when shadow-to-active commit occurs.
REQ-012 The config address map SHALL be: 0=width_high, 1=width_period, 2=start_delay_s, 3=control (bit0 arm, bit1 stop); writes SHALL go to the shadow registers of channel i_cfg_ch.
REQ-013 On pps_tick, the shadow widths of every channel in state IDLE or ARMED SHALL copy to the active outputs; a RUNNING channel SHALL keep its widths until stopped.
REQ-014 Each channel SHALL have states IDLE(0), ARMED(1), COUNTDOWN(2), RUNNING(3) and FAULT(4).
REQ-015 IDLE->ARMED SHALL occur on a control write with arm=1, provided shadow width_period!=0 and width_high<=width_period; otherwise the write is ignored.
REQ-016 ARMED->COUNTDOWN SHALL occur on the next pps_tick, loading the countdown with start_delay_s.
REQ-017 In COUNTDOWN, each pps_tick SHALL decrement the counter; on the tick where the counter is 0 the channel SHALL go to RUNNING, with o_ch_enable asserted on the following cycle.
REQ-018 A delay of 0 SHALL therefore give RUNNING on the first pps_tick after ARMED.
REQ-019 A control write with stop=1 SHALL force any non-FAULT state to IDLE and deassert o_ch_enable next cycle; stop SHALL take priority over arm in the same write.
REQ-020 When pps_tick and a cfg write to the same channel coincide, o_cfg_ready=0 SHALL hold the write, so the pps_tick action wins and the write lands on the next cycle.
REQ-021 The PPS watchdog SHALL count clocks since the last pps_tick and saturate; at PPS_TIMEOUT_CLKS it SHALL set o_pps_lost and move every non-IDLE channel to FAULT with enable low.
REQ-022 FAULT SHALL exit only via a stop write, to IDLE; o_pps_lost SHALL clear on the next pps_tick.
REQ-023 The countdown SHALL be 32 bits wide with no wrap below 0.

Reset
REQ-024 When i_rst_n=0 at a clock edge, all channels SHALL go to IDLE, and shadow and active registers, o_ch_enable, o_width_high, o_width_period, the watchdog and o_pps_lost SHALL all go to 0.
REQ-025 During reset, o_cfg_ready SHALL be 0.
REQ-026 Reset asserted mid-RUNNING SHALL drop o_ch_enable on the next cycle with no partial pulse handling.

Structure
REQ-027 Shared package pulse_sched_pkg SHALL hold the state encodings, the config address and control-bit constants, and the 3-bit state width.
REQ-028 Sub-module pulse_sched_channel SHALL hold one channel's shadow/active registers, FSM and countdown, instantiated NUM_CH times; PPS sync, watchdog and write decode SHALL stay in the top level.

Verification
REQ-029 The bench SHALL cover: write ch0 width_high=5, period=10, delay=2, arm; apply 3 PPS edges -> ch0 state 1->2->2->3, enable high 1 clk after the 3rd tick, widths 5/10.
REQ-030 The bench SHALL cover: arm ch1 with width_high=20, period=10 -> write ignored, state stays 0.
REQ-031 The bench SHALL cover: ch0 RUNNING, write period=50 then PPS -> active period stays 10; stop then PPS -> enable low, period becomes 50.
REQ-032 The bench SHALL cover: cfg write asserted on the pps_tick cycle -> o_cfg_ready=0 that cycle, write accepted the next cycle.
REQ-033 The bench SHALL cover: PPS_TIMEOUT_CLKS=100, ch2 RUNNING, no PPS for 100 clks -> o_pps_lost=1, ch2 FAULT, enable 0; stop -> IDLE; next PPS -> o_pps_lost=0.
REQ-034 The bench SHALL cover: i_rst_n low for 1 clk during RUNNING -> all outputs 0 and all states 0 next cycle.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg: state encodings and config map shared by the pulse scheduler.
package pulse_sched_pkg;
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_COUNTDOWN = 3'd2,
      ST_RUNNING   = 3'd3,
      ST_FAULT     = 3'd4
   } ch_state_e;
   localparam logic [1:0] ADDR_HIGH   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_DELAY  = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;
   localparam int CTRL_ARM  = 0;
   localparam int CTRL_STOP = 1;
endpackage

// File: rtl/pulse_sched_channel.sv
// pulse_sched_channel: one channel's shadow/active widths, start countdown and state machine.
module pulse_sched_channel
   import pulse_sched_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_tick,
   input  logic               i_timeout,
   input  logic               i_wr,
   input  logic [1:0]         i_addr,
   input  logic [31:0]        i_data,
   output logic               o_enable,
   output logic [31:0]        o_width_high,
   output logic [31:0]        o_width_period,
   output logic [STATE_W-1:0] o_state
);
   ch_state_e   state_q;
   logic [31:0] high_q, period_q, delay_q, cnt_q, act_high_q, act_period_q;
   logic        en_q;
   logic        wr_ctrl, stop, arm;

   assign wr_ctrl = i_wr && (i_addr == ADDR_CTRL);
   assign stop    = wr_ctrl && i_data[CTRL_STOP];
   assign arm     = wr_ctrl && i_data[CTRL_ARM] && (period_q != 32'd0) && (high_q <= period_q);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         en_q         <= 1'b0;
         cnt_q        <= '0;
         high_q       <= '0;
         period_q     <= '0;
         delay_q      <= '0;
         act_high_q   <= '0;
         act_period_q <= '0;
      end else begin
         if (i_wr && i_addr == ADDR_HIGH) high_q <= i_data;
         if (i_wr && i_addr == ADDR_PERIOD) period_q <= i_data;
         if (i_wr && i_addr == ADDR_DELAY) delay_q <= i_data;
         if (i_tick && (state_q == ST_IDLE || state_q == ST_ARMED)) begin
            act_high_q   <= high_q;
            act_period_q <= period_q;
         end
         if (stop) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
         end else if (i_timeout && state_q != ST_IDLE) begin
            state_q <= ST_FAULT;
            en_q    <= 1'b0;
         end else if (arm && state_q == ST_IDLE) begin
            state_q <= ST_ARMED;
         end else if (i_tick && state_q == ST_ARMED) begin
            state_q <= (delay_q == 32'd0) ? ST_RUNNING : ST_COUNTDOWN;
            en_q    <= (delay_q == 32'd0);
            cnt_q   <= delay_q;
         end else if (i_tick && state_q == ST_COUNTDOWN) begin
            // Start on the tick that brings the count to zero; never wrap.
            cnt_q <= (cnt_q == 32'd0) ? 32'd0 : cnt_q - 32'd1;
            if (cnt_q <= 32'd1) begin
               state_q <= ST_RUNNING;
               en_q    <= 1'b1;
            end
         end
      end
   end

   assign o_enable       = en_q;
   assign o_width_high   = act_high_q;
   assign o_width_period = act_period_q;
   assign o_state        = state_q;
endmodule

// File: rtl/pulse_schedule_ctrl.sv
// pulse_schedule_ctrl: PPS-aligned multi-channel pulse scheduler with host config
// writes, shadow-to-active commit on PPS and a PPS-loss watchdog.
module pulse_schedule_ctrl
   import pulse_sched_pkg::*;
#(
   parameter int          NUM_CH           = 4,
   parameter logic [31:0] PPS_TIMEOUT_CLKS = 32'd12_000_000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_pps_raw,
   input  logic                    i_cfg_valid,
   output logic                    o_cfg_ready,
   input  logic [1:0]              i_cfg_ch,
   input  logic [1:0]              i_cfg_addr,
   input  logic [31:0]             i_cfg_data,
   output logic [NUM_CH-1:0]       o_ch_enable,
   output logic [32*NUM_CH-1:0]    o_width_high,
   output logic [32*NUM_CH-1:0]    o_width_period,
   output logic                    o_pps_lost,
   output logic [STATE_W*NUM_CH-1:0] o_ch_state
);
   logic [2:0]  sync_q;
   logic [31:0] wd_q, wd_d;
   logic        lost_q, pps_tick, timeout, wr;

   // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the previous synced value.
   assign pps_tick    = sync_q[1] & ~sync_q[2];
   assign o_cfg_ready = i_rst_n & ~pps_tick;
   assign wr          = i_cfg_valid & o_cfg_ready;
   assign timeout     = ~pps_tick && (wd_q == PPS_TIMEOUT_CLKS - 32'd1);
   assign wd_d        = pps_tick ? 32'd0 : (wd_q == PPS_TIMEOUT_CLKS) ? wd_q : wd_q + 32'd1;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync_q <= '0;
         wd_q   <= '0;
         lost_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], i_pps_raw};
         wd_q   <= wd_d;
         lost_q <= pps_tick ? 1'b0 : (timeout ? 1'b1 : lost_q);
      end
   end

   assign o_pps_lost = lost_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pulse_sched_channel u_ch (
         .i_clk          (i_clk),
         .i_rst_n        (i_rst_n),
         .i_tick         (pps_tick),
         .i_timeout      (timeout),
         .i_wr           (wr && (i_cfg_ch == 2'(g))),
         .i_addr         (i_cfg_addr),
         .i_data         (i_cfg_data),
         .o_enable       (o_ch_enable[g]),
         .o_width_high   (o_width_high[32*g +: 32]),
         .o_width_period (o_width_period[32*g +: 32]),
         .o_state        (o_ch_state[STATE_W*g +: STATE_W])
      );
   end
endmodule

// File: tb/tb_pulse_schedule_ctrl.sv
// tb_pulse_schedule_ctrl: scenario tasks plus randomized traffic against an
// event-level model that tracks ticks elapsed since arming.
module tb_pulse_schedule_ctrl;
   logic         clk = 1'b0, rst_n = 1'b0, pps = 1'b0;
   logic         valid = 1'b0, ready;
   logic [1:0]   cch = '0, caddr = '0;
   logic [31:0]  cdata = '0;
   logic [3:0]   en;
   logic [127:0] wh, wp;
   logic         lost;
   logic [11:0]  st_o;
   logic [272:0] obs;
   int checks = 0, errors = 0;

   int          st[4], tsa[4];
   logic [31:0] sh_h[4], sh_p[4], sh_d[4], ac_h[4], ac_p[4], dl[4];
   bit          m_lost;

   pulse_schedule_ctrl #(.NUM_CH(4), .PPS_TIMEOUT_CLKS(32'd100)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pps_raw(pps),
      .i_cfg_valid(valid), .o_cfg_ready(ready), .i_cfg_ch(cch), .i_cfg_addr(caddr), .i_cfg_data(cdata),
      .o_ch_enable(en), .o_width_high(wh), .o_width_period(wp), .o_pps_lost(lost), .o_ch_state(st_o)
   );

   always #5 clk = ~clk;
   assign obs = {st_o, en, wh, wp, lost};

   initial begin
      #2_000_000;
      $display("FAIL global_timeout sim did not finish");
      $fatal(1, "timeout");
   end

   function automatic void model_reset();
      for (int c = 0; c < 4; c++) begin
         st[c] = 0; tsa[c] = 0;
         sh_h[c] = 0; sh_p[c] = 0; sh_d[c] = 0; ac_h[c] = 0; ac_p[c] = 0; dl[c] = 0;
      end
      m_lost = 0;
   endfunction

   function automatic void model_write(int ch, int addr, logic [31:0] d);
      if (addr == 0) sh_h[ch] = d;
      else if (addr == 1) sh_p[ch] = d;
      else if (addr == 2) sh_d[ch] = d;
      else if (d[1]) st[ch] = 0;
      else if (d[0] && st[ch] == 0 && sh_p[ch] != 0 && sh_h[ch] <= sh_p[ch]) begin
         st[ch] = 1; tsa[ch] = 0;
      end
   endfunction

   // A channel runs once delay+1 ticks have passed since arming.
   function automatic void model_tick();
      m_lost = 0;
      for (int c = 0; c < 4; c++) begin
         if (st[c] == 0 || st[c] == 1) begin ac_h[c] = sh_h[c]; ac_p[c] = sh_p[c]; end
         if (st[c] == 1) dl[c] = sh_d[c];
         if (st[c] == 1 || st[c] == 2) begin
            tsa[c]++;
            st[c] = (tsa[c] > int'(dl[c])) ? 3 : 2;
         end
      end
   endfunction

   function automatic void model_timeout();
      for (int c = 0; c < 4; c++) if (st[c] != 0) st[c] = 4;
      m_lost = 1;
   endfunction

   function automatic logic [272:0] exp_all();
      logic [11:0] s; logic [3:0] e; logic [127:0] h, p;
      for (int c = 0; c < 4; c++) begin
         s[c*3 +: 3] = 3'(st[c]); e[c] = (st[c] == 3);
         h[c*32 +: 32] = ac_h[c]; p[c*32 +: 32] = ac_p[c];
      end
      return {s, e, h, p, m_lost};
   endfunction

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic cfg_write(int ch, int addr, logic [31:0] d);
      bit done = 0;
      valid = 1; cch = 2'(ch); caddr = 2'(addr); cdata = d;
      for (int i = 0; i < 4 && !done; i++) begin
         done = ready;
         cyc();
      end
      valid = 0;
      checks++;
      if (!done) begin errors++; $display("FAIL cfg_accept ch=%0d addr=%0d never accepted", ch, addr); end
      else model_write(ch, addr, d);
   endtask

   task automatic pps_pulse();
      pps = 1; repeat (4) cyc();
      pps = 0; repeat (2) cyc();
      model_tick();
   endtask

   task automatic test_reset();
      rst_n = 0; model_reset();
      repeat (3) cyc();
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
      checks++; if (obs !== exp_all()) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, exp_all()); end
      rst_n = 1; cyc();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
   endtask

   task automatic test_basic();
      cfg_write(0, 0, 5); cfg_write(0, 1, 10); cfg_write(0, 2, 2); cfg_write(0, 3, 1);
      checks++; if (st_o[2:0] !== 3'd1) begin errors++; $display("FAIL basic_armed got=%0d exp=1", st_o[2:0]); end
      pps_pulse();
      checks++; if (st_o[2:0] !== 3'd2) begin errors++; $display("FAIL basic_tick1 got=%0d exp=2", st_o[2:0]); end
      pps_pulse();
      checks++; if (st_o[2:0] !== 3'd2) begin errors++; $display("FAIL basic_tick2 got=%0d exp=2", st_o[2:0]); end
      pps = 1; cyc(); cyc();
      checks++; if ({ready, en[0]} !== 2'b00) begin errors++; $display("FAIL basic_tick_cycle got ready/en=%b exp=00", {ready, en[0]}); end
      cyc(); model_tick();
      checks++; if ({st_o[2:0], en[0]} !== {3'd3, 1'b1}) begin errors++; $display("FAIL basic_running got st=%0d en=%b exp st=3 en=1", st_o[2:0], en[0]); end
      checks++; if ({wh[31:0], wp[31:0]} !== {32'd5, 32'd10}) begin errors++; $display("FAIL basic_widths got=%0d/%0d exp=5/10", wh[31:0], wp[31:0]); end
      pps = 0; repeat (3) cyc();
      checks++; if (obs !== exp_all()) begin errors++; $display("FAIL basic_all got=%h exp=%h", obs, exp_all()); end
   endtask

   task automatic test_invalid_arm();
      cfg_write(1, 0, 20); cfg_write(1, 1, 10); cfg_write(1, 3, 1);
      checks++; if (st_o[5:3] !== 3'd0) begin errors++; $display("FAIL arm_high_gt_period got=%0d exp=0", st_o[5:3]); end
      cfg_write(1, 0, 0); cfg_write(1, 1, 0); cfg_write(1, 3, 1);
      checks++; if (st_o[5:3] !== 3'd0) begin errors++; $display("FAIL arm_zero_period got=%0d exp=0", st_o[5:3]); end
      cfg_write(1, 0, 10); cfg_write(1, 1, 10); cfg_write(1, 3, 3);
      checks++; if (st_o[5:3] !== 3'd0) begin errors++; $display("FAIL arm_stop_priority got=%0d exp=0", st_o[5:3]); end
      cfg_write(1, 3, 1);
      checks++; if (st_o[5:3] !== 3'd1) begin errors++; $display("FAIL arm_equal_ok got=%0d exp=1", st_o[5:3]); end
      cfg_write(1, 3, 2);
      checks++; if (obs !== exp_all()) begin errors++; $display("FAIL arm_all got=%h exp=%h", obs, exp_all()); end
   endtask

   task automatic test_hold_running();
      cfg_write(0, 1, 50);
      pps_pulse();
      checks++; if ({wp[31:0], en[0]} !== {32'd10, 1'b1}) begin errors++; $display("FAIL hold_period got=%0d en=%b exp=10 en=1", wp[31:0], en[0]); end
      cfg_write(0, 3, 2);
      checks++; if ({st_o[2:0], en[0]} !== {3'd0, 1'b0}) begin errors++; $display("FAIL hold_stop got st=%0d en=%b exp st=0 en=0", st_o[2:0], en[0]); end
      pps_pulse();
      checks++; if (wp[31:0] !== 32'd50) begin errors++; $display("FAIL hold_commit got=%0d exp=50", wp[31:0]); end
      checks++; if (obs !== exp_all()) begin errors++; $display("FAIL hold_all got=%h exp=%h", obs, exp_all()); end
   endtask

   task automatic test_back_to_back();
      cfg_write(3, 0, 7);
      pps_pulse();
      pps = 1; cyc(); cyc();
      valid = 1; cch = 2'd3; caddr = 2'd0; cdata = 32'd9;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL collide_ready_tick got=%b exp=0", ready); end
      cyc(); model_tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL collide_ready_after got=%b exp=1", ready); end
      cyc(); valid = 0; model_write(3, 0, 9);
      checks++; if (wh[127:96] !== 32'd7) begin errors++; $display("FAIL collide_tick_wins got=%0d exp=7", wh[127:96]); end
      pps = 0; repeat (2) cyc();
      pps_pulse();
      checks++; if (wh[127:96] !== 32'd9) begin errors++; $display("FAIL collide_write_landed got=%0d exp=9", wh[127:96]); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 30; r++) begin
         for (int w = 0, n = $urandom_range(0, 4); w < n; w++) begin
            int ch = $urandom_range(0, 3), a = $urandom_range(0, 3);
            logic [31:0] d = (a == 3) ? 32'($urandom_range(0, 3)) : (a == 2) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 20));
            cfg_write(ch, a, d);
            checks++; if (obs !== exp_all()) begin errors++; $display("FAIL rand_write r=%0d got=%h exp=%h", r, obs, exp_all()); end
         end
         pps_pulse();
         checks++; if (obs !== exp_all()) begin errors++; $display("FAIL rand_tick r=%0d got=%h exp=%h", r, obs, exp_all()); end
      end
   endtask

   task automatic test_timeout();
      for (int c = 0; c < 4; c++) cfg_write(c, 3, 2);
      cfg_write(2, 0, 3); cfg_write(2, 1, 7); cfg_write(2, 2, 0); cfg_write(2, 3, 1);
      pps_pulse();
      checks++; if (st_o[8:6] !== 3'd3) begin errors++; $display("FAIL wd_running got=%0d exp=3", st_o[8:6]); end
      repeat (90) cyc();
      checks++; if (lost !== 1'b0) begin errors++; $display("FAIL wd_early got=%b exp=0", lost); end
      repeat (20) cyc(); model_timeout();
      checks++; if ({lost, st_o[8:6], en[2]} !== {1'b1, 3'd4, 1'b0}) begin errors++; $display("FAIL wd_fault got lost=%b st=%0d en=%b exp 1/4/0", lost, st_o[8:6], en[2]); end
      checks++; if (obs !== exp_all()) begin errors++; $display("FAIL wd_all got=%h exp=%h", obs, exp_all()); end
      cfg_write(2, 3, 2);
      checks++; if ({lost, st_o[8:6]} !== {1'b1, 3'd0}) begin errors++; $display("FAIL wd_stop got lost=%b st=%0d exp 1/0", lost, st_o[8:6]); end
      pps_pulse();
      checks++; if (lost !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", lost); end
   endtask

   task automatic test_reset_running();
      cfg_write(1, 0, 2); cfg_write(1, 1, 4); cfg_write(1, 2, 0); cfg_write(1, 3, 1);
      pps_pulse();
      checks++; if (en[1] !== 1'b1) begin errors++; $display("FAIL rst_run_en got=%b exp=1", en[1]); end
      rst_n = 0; cyc(); model_reset();
      checks++; if ({obs, ready} !== {exp_all(), 1'b0}) begin errors++; $display("FAIL rst_run_clear got=%h exp=%h", {obs, ready}, {exp_all(), 1'b0}); end
      rst_n = 1; cyc();
      checks++; if ({st_o, ready} !== {12'd0, 1'b1}) begin errors++; $display("FAIL rst_run_release got=%h exp=%h", {st_o, ready}, {12'd0, 1'b1}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_invalid_arm();
      test_hold_running();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_running();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
